// File: rtl/jtag_scan_master.sv
// rtl/jtag_scan_master.sv - host-side JTAG initiator: one IR or DR scan from Run-Test/Idle back to Idle
module jtag_scan_master #(
    parameter int MAX_LEN = 32,
    parameter int LEN_W   = 6
) (
    input  logic               Clock,
    input  logic               ResetN,
    input  logic               Start,
    input  logic               IsIR,
    input  logic [LEN_W-1:0]   Len,
    input  logic [MAX_LEN-1:0] DataIn,
    input  logic               TDO,
    output logic               TCK,
    output logic               TMS,
    output logic               TDI,
    output logic               Busy,
    output logic               Done,
    output logic               Error,
    output logic [MAX_LEN-1:0] DataOut
);

    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_IDLE  = 3'd1,
        S_HDR   = 3'd2,
        S_SHIFT = 3'd3,
        S_TAIL  = 3'd4
    } state_t;

    localparam logic [LEN_W-1:0] ZERO        = LEN_W'(0);
    localparam logic [LEN_W-1:0] ONE         = LEN_W'(1);
    localparam logic [LEN_W-1:0] INIT_LAST   = LEN_W'(5);
    localparam logic [LEN_W-1:0] HDR_LAST_DR = LEN_W'(2);
    localparam logic [LEN_W-1:0] HDR_LAST_IR = LEN_W'(3);
    localparam logic [LEN_W-1:0] TAIL_LAST   = LEN_W'(1);
    localparam logic [LEN_W-1:0] MAX_L       = LEN_W'(MAX_LEN);

    state_t             state, state_n;
    logic               phase, phase_n;     // 0 = TCK low half, 1 = TCK high half
    logic [LEN_W-1:0]   cnt, cnt_n;         // step index within the current segment
    logic               tck, tck_n;
    logic               tms, tms_n;
    logic               tdi, tdi_n;
    logic               busy, busy_n;
    logic               done, done_n;
    logic               error, error_n;
    logic               ir_q;
    logic [LEN_W-1:0]   len_q;
    logic [MAX_LEN-1:0] shift_q;            // outgoing bits, bit 1 is the next TDI value
    logic [MAX_LEN-1:0] sel_q;              // one-hot position of the bit being captured
    logic [MAX_LEN-1:0] cap_q;
    logic [MAX_LEN-1:0] data_out;
    logic               accept;
    logic               sample;
    logic               advance;
    logic               finish;
    logic [LEN_W-1:0]   last_shift;
    logic [LEN_W-1:0]   hdr_last;

    assign last_shift = len_q - ONE;
    assign hdr_last   = ir_q ? HDR_LAST_IR : HDR_LAST_DR;

    // Next-state and next-output logic; TMS/TDI only change when entering a TCK low half
    always_comb begin
        state_n = state;
        phase_n = phase;
        cnt_n   = cnt;
        tck_n   = tck;
        tms_n   = tms;
        tdi_n   = tdi;
        busy_n  = busy;
        done_n  = 1'b0;
        error_n = 1'b0;
        accept  = 1'b0;
        sample  = 1'b0;
        advance = 1'b0;
        finish  = 1'b0;
        case (state)
            S_IDLE: begin
                tck_n  = 1'b0;
                tms_n  = 1'b0;
                tdi_n  = 1'b0;
                busy_n = 1'b0;
                if (Start) begin
                    if (Len == ZERO || Len > MAX_L) begin
                        done_n  = 1'b1;
                        error_n = 1'b1;
                    end else begin
                        accept  = 1'b1;
                        state_n = S_HDR;
                        phase_n = 1'b0;
                        cnt_n   = ZERO;
                        busy_n  = 1'b1;
                        tms_n   = 1'b1;
                    end
                end
            end
            default: begin
                if (!phase) begin
                    phase_n = 1'b1;
                    tck_n   = 1'b1;
                    sample  = (state == S_SHIFT);
                end else begin
                    phase_n = 1'b0;
                    tck_n   = 1'b0;
                    cnt_n   = cnt + ONE;
                    tdi_n   = 1'b0;
                    case (state)
                        S_INIT: begin
                            if (cnt == INIT_LAST) begin
                                state_n = S_IDLE;
                                busy_n  = 1'b0;
                                tms_n   = 1'b0;
                            end else begin
                                tms_n = ((cnt + ONE) != INIT_LAST);
                            end
                        end
                        S_HDR: begin
                            if (cnt == hdr_last) begin
                                state_n = S_SHIFT;
                                cnt_n   = ZERO;
                                tms_n   = (last_shift == ZERO);
                                tdi_n   = shift_q[0];
                            end else begin
                                tms_n = ir_q && (cnt == ZERO);
                            end
                        end
                        S_SHIFT: begin
                            if (cnt == last_shift) begin
                                state_n = S_TAIL;
                                cnt_n   = ZERO;
                                tms_n   = 1'b1;
                            end else begin
                                advance = 1'b1;
                                tms_n   = ((cnt + ONE) == last_shift);
                                tdi_n   = shift_q[1];
                            end
                        end
                        S_TAIL: begin
                            if (cnt == TAIL_LAST) begin
                                state_n = S_IDLE;
                                busy_n  = 1'b0;
                                done_n  = 1'b1;
                                finish  = 1'b1;
                            end
                            tms_n = 1'b0;
                        end
                        default: begin
                            state_n = S_INIT;
                            cnt_n   = ZERO;
                            tms_n   = 1'b1;
                            busy_n  = 1'b1;
                        end
                    endcase
                end
            end
        endcase
    end

    // Control registers; reset parks the TAP driver in the low half of INIT step 0
    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            state <= S_INIT;
            phase <= 1'b0;
            cnt   <= ZERO;
            tck   <= 1'b0;
            tms   <= 1'b1;
            tdi   <= 1'b0;
            busy  <= 1'b1;
            done  <= 1'b0;
            error <= 1'b0;
        end else begin
            state <= state_n;
            phase <= phase_n;
            cnt   <= cnt_n;
            tck   <= tck_n;
            tms   <= tms_n;
            tdi   <= tdi_n;
            busy  <= busy_n;
            done  <= done_n;
            error <= error_n;
        end
    end

    // Scan datapath: latch request, shift TDI bits out, collect TDO bits, publish on completion
    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            ir_q     <= 1'b0;
            len_q    <= ZERO;
            shift_q  <= '0;
            sel_q    <= '0;
            cap_q    <= '0;
            data_out <= '0;
        end else begin
            if (accept) begin
                ir_q    <= IsIR;
                len_q   <= Len;
                shift_q <= DataIn;
                sel_q   <= MAX_LEN'(1);
                cap_q   <= '0;
            end
            if (sample) begin
                cap_q <= cap_q | (sel_q & {MAX_LEN{TDO}});
            end
            if (advance) begin
                shift_q <= shift_q >> 1;
                sel_q   <= sel_q << 1;
            end
            if (finish) begin
                data_out <= cap_q;
            end
        end
    end

    assign TCK     = tck;
    assign TMS     = tms;
    assign TDI     = tdi;
    assign Busy    = busy;
    assign Done    = done;
    assign Error   = error;
    assign DataOut = data_out;

endmodule

// File: tb/tb_jtag_scan_master.sv
// tb/tb_jtag_scan_master.sv - self-checking bench for jtag_scan_master
module tb_jtag_scan_master;

    logic        Clock;
    logic        ResetN;
    logic        Start;
    logic        IsIR;
    logic [5:0]  Len;
    logic [31:0] DataIn;
    logic        TDO;
    logic        TCK;
    logic        TMS;
    logic        TDI;
    logic        Busy;
    logic        Done;
    logic        Error;
    logic [31:0] DataOut;

    int checks;
    int failures;
    int mode;               // 0 = one-flop chain (bypass-like), 1 = TDO wired to TDI
    logic tdo_q;
    int rises;
    logic tms_log [8192];
    logic tdi_log [8192];
    logic [31:0] last_data;

    jtag_scan_master #(.MAX_LEN(32), .LEN_W(6)) dut (
        .Clock(Clock), .ResetN(ResetN), .Start(Start), .IsIR(IsIR), .Len(Len),
        .DataIn(DataIn), .TDO(TDO), .TCK(TCK), .TMS(TMS), .TDI(TDI), .Busy(Busy),
        .Done(Done), .Error(Error), .DataOut(DataOut)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    assign TDO = (mode == 1) ? TDI : tdo_q;

    // Chain model and TCK-rise logger
    initial begin
        tdo_q = 1'b0;
        rises = 0;
    end
    always @(posedge TCK) begin
        if (rises < 8192) begin
            tms_log[rises] = TMS;
            tdi_log[rises] = TDI;
        end
        rises = rises + 1;
        tdo_q <= TDI;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Reference model: expected step count, timing and pin sequences from the scan rules
    task automatic model(input logic ir, input int len, input logic [31:0] data, input int md,
                         output int s, output int exp_n, output logic err,
                         output logic [31:0] exp_do, output logic [63:0] exp_tms,
                         output logic [63:0] exp_tdi);
        int hdr;
        logic [63:0] mask;
        logic [63:0] full;
        err   = (len == 0) || (len > 32);
        hdr   = ir ? 4 : 3;
        s     = err ? 0 : hdr + len + 2;
        exp_n = err ? 1 : 2 * s + 1;
        mask  = (64'd1 << len) - 64'd1;
        full  = {32'd0, data};
        exp_do  = (md == 1) ? 32'(full & mask) : 32'((full << 1) & mask);
        exp_tms = '0;
        exp_tdi = '0;
        if (!err) begin
            exp_tms[0] = 1'b1;
            if (ir) exp_tms[1] = 1'b1;
            exp_tms[hdr + len - 1] = 1'b1;
            exp_tms[hdr + len]     = 1'b1;
            for (int i = 0; i < len; i++) exp_tdi[hdr + i] = data[i];
        end
    endtask

    // Issue one request from a negedge, wait for Done, compare against expectations
    task automatic check_scan(input string tag, input logic ir, input int len,
                              input logic [31:0] data, input int md, input int poke,
                              input int exp_n, input logic exp_err, input logic [31:0] exp_do);
        int s, mn, base, n;
        logic merr;
        logic [31:0] mdo;
        logic [63:0] mtms, mtdi, atms, atdi;
        logic got, err_seen, busy_seen, busy_any;
        model(ir, len, data, md, s, mn, merr, mdo, mtms, mtdi);
        mode   = md;
        IsIR   = ir;
        Len    = len[5:0];
        DataIn = data;
        Start  = 1'b1;
        base   = rises;
        @(posedge Clock);
        #1;
        Start = 1'b0;
        n = 0;
        got = 1'b0;
        err_seen = 1'b0;
        busy_seen = 1'b1;
        busy_any = 1'b0;
        while (!got && n < 200) begin
            @(negedge Clock);
            n++;
            if (poke != 0) begin
                Start = (n == poke);
                if (n == poke) Len = '0;
            end
            busy_any = busy_any | Busy;
            if (Done) begin
                got = 1'b1;
                err_seen = Error;
                busy_seen = Busy;
            end
        end
        chk({tag, "_done_cycle"}, 64'(n), 64'(exp_n));
        chk({tag, "_error"}, 64'(err_seen), 64'(exp_err));
        chk({tag, "_busy_at_done"}, 64'(busy_seen), 64'd0);
        if (exp_err) begin
            chk({tag, "_dataout_held"}, 64'(DataOut), 64'(last_data));
            chk({tag, "_no_tck"}, 64'(rises - base), 64'd0);
            chk({tag, "_busy_low"}, 64'(busy_any), 64'd0);
        end else begin
            chk({tag, "_dataout"}, 64'(DataOut), 64'(exp_do));
            last_data = exp_do;
            chk({tag, "_tck_steps"}, 64'(rises - base), 64'(s));
            atms = '0;
            atdi = '0;
            for (int j = 0; j < s && j < 64; j++) begin
                atms[j] = tms_log[base + j];
                atdi[j] = tdi_log[base + j];
            end
            chk({tag, "_tms_seq"}, atms, mtms);
            chk({tag, "_tdi_seq"}, atdi, mtdi);
        end
    endtask

    // Apply reset for one edge from a negedge, check reset values, then the INIT walk
    task automatic reset_check(input string tag);
        int base, n;
        logic done_seen;
        logic [63:0] atms;
        ResetN = 1'b0;
        Start  = 1'b0;
        @(posedge Clock);
        @(negedge Clock);
        chk({tag, "_rst_tck"}, 64'(TCK), 64'd0);
        chk({tag, "_rst_tms"}, 64'(TMS), 64'd1);
        chk({tag, "_rst_tdi"}, 64'(TDI), 64'd0);
        chk({tag, "_rst_busy"}, 64'(Busy), 64'd1);
        chk({tag, "_rst_done_err"}, 64'({Done, Error}), 64'd0);
        chk({tag, "_rst_dataout"}, 64'(DataOut), 64'd0);
        last_data = '0;
        ResetN = 1'b1;
        base = rises;
        n = 0;
        done_seen = 1'b0;
        while (Busy && n < 100) begin
            @(negedge Clock);
            n++;
            if (Done) done_seen = 1'b1;
        end
        chk({tag, "_init_busy_fall"}, 64'(n), 64'd12);
        chk({tag, "_init_tck_steps"}, 64'(rises - base), 64'd6);
        atms = '0;
        for (int j = 0; j < 6; j++) atms[j] = tms_log[base + j];
        chk({tag, "_init_tms_seq"}, atms, 64'h1F);
        chk({tag, "_init_no_done"}, 64'(done_seen), 64'd0);
    endtask

    typedef struct {
        logic        ir;
        int          len;
        logic [31:0] data;
        int          md;
        int          exp_n;
        logic        exp_err;
        logic [31:0] exp_do;
    } vec_t;

    vec_t vecs [9];

    initial begin
        int s, en;
        logic er;
        logic [31:0] edo;
        logic [63:0] et, ed;
        logic ir;
        int len, md;
        logic [31:0] data;
        checks = 0;
        failures = 0;
        mode = 0;
        ResetN = 1'b0;
        Start = 1'b0;
        IsIR = 1'b0;
        Len = '0;
        DataIn = '0;
        last_data = '0;

        vecs[0] = '{1'b0,  2, 32'h0000_0003, 0, 15, 1'b0, 32'h0000_0002};
        vecs[1] = '{1'b1,  4, 32'h0000_000A, 0, 21, 1'b0, 32'h0000_0004};
        vecs[2] = '{1'b0, 32, 32'hDEAD_BEEF, 1, 75, 1'b0, 32'hDEAD_BEEF};
        vecs[3] = '{1'b0,  0, 32'h1234_5678, 1,  1, 1'b1, 32'h0};
        vecs[4] = '{1'b0, 33, 32'h1234_5678, 1,  1, 1'b1, 32'h0};
        vecs[5] = '{1'b0,  1, 32'h0000_0001, 1, 13, 1'b0, 32'h0000_0001};
        vecs[6] = '{1'b1, 32, 32'h8000_0001, 0, 77, 1'b0, 32'h0000_0002};
        vecs[7] = '{1'b1, 63, 32'hFFFF_FFFF, 1,  1, 1'b1, 32'h0};
        vecs[8] = '{1'b1,  3, 32'h0000_0005, 1, 19, 1'b0, 32'h0000_0005};

        repeat (3) @(negedge Clock);
        reset_check("init");

        // Directed vectors, issued back-to-back (each Start lands in the previous Done cycle)
        foreach (vecs[i]) begin
            check_scan($sformatf("vec%0d", i), vecs[i].ir, vecs[i].len, vecs[i].data,
                       vecs[i].md, 0, vecs[i].exp_n, vecs[i].exp_err, vecs[i].exp_do);
        end

        // Start pulsed (with an illegal length) while a scan is in flight must be ignored
        check_scan("busy_poke", 1'b0, 8, 32'h0000_005A, 1, 9, 27, 1'b0, 32'h0000_005A);

        // Randomized scans against the reference model
        for (int r = 0; r < 25; r++) begin
            ir = 1'($urandom_range(0, 1));
            md = int'($urandom_range(0, 1));
            data = $urandom;
            if ($urandom_range(0, 7) == 0)
                len = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(33, 63));
            else
                len = int'($urandom_range(1, 32));
            model(ir, len, data, md, s, en, er, edo, et, ed);
            check_scan($sformatf("rnd%0d", r), ir, len, data, md, 0, en, er, edo);
        end

        // Reset arriving in the middle of SHIFT
        mode = 1;
        IsIR = 1'b0;
        Len = 6'd16;
        DataIn = $urandom;
        Start = 1'b1;
        @(posedge Clock);
        #1;
        Start = 1'b0;
        repeat (10) @(negedge Clock);
        chk("mid_busy_before_reset", 64'(Busy), 64'd1);
        reset_check("mid");
        check_scan("after_reset", 1'b0, 2, 32'h0000_0003, 0, 0, 15, 1'b0, 32'h0000_0002);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
